// File: rtl/butterfly_core_scaled.sv
// Radix-2 DIT butterfly with valid/ready backpressure, runtime inverse mode,
// optional divide-by-2 with rounding, output saturation and overflow flags.
module butterfly_core_scaled #(
  parameter int FFT_N    = 10,
  parameter int FFT_DW   = 16,
  parameter int TW_DW    = 16,
  parameter int STAGE_BW = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [STAGE_BW-1:0]   fft_stage,
  input  logic                  inverse,
  input  logic                  scale_shift,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_ctrl,
  input  logic [FFT_N-2:0]      in_addr,
  input  logic [2*FFT_DW-1:0]   in_a,
  input  logic [2*FFT_DW-1:0]   in_b,
  input  logic [TW_DW-1:0]      tw_re,
  input  logic [TW_DW-1:0]      tw_im,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_ctrl,
  output logic [FFT_N-2:0]      out_addr,
  output logic [2*FFT_DW-1:0]   out_a,
  output logic [2*FFT_DW-1:0]   out_b,
  output logic                  out_ovf,
  output logic                  ovf_sticky,
  input  logic                  ovf_clear,
  output logic                  stage_err
);

  localparam int PW = FFT_DW + TW_DW + 1;
  localparam int RW = FFT_DW + 2;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_DW - 2);
  localparam logic signed [TW_DW-1:0] TW_MIN = {1'b1, {(TW_DW-1){1'b0}}};
  localparam logic signed [TW_DW-1:0] TW_MAX = {1'b0, {(TW_DW-1){1'b1}}};
  localparam logic signed [RW:0] S_MAX = (RW+1)'((1 << (FFT_DW - 1)) - 1);
  localparam logic signed [RW:0] S_MIN = -S_MAX - (RW+1)'(1);

  // Handshake: a beat moves on any edge where valid & ready are both high.
  // The whole pipe advances together on ce; the input is ready exactly when
  // the output register is empty or being drained this cycle.
  logic ce;
  assign ce       = ~out_valid | out_ready;
  assign in_ready = ce;

  logic stage_ok;
  assign stage_ok = 32'(fft_stage) < FFT_N;

  // S1: captured beat
  logic                     v1, inv1, scl1;
  logic [1:0]               ctrl1;
  logic [FFT_N-2:0]         addr1;
  logic signed [FFT_DW-1:0] ar1, ai1, br1, bi1;
  logic signed [TW_DW-1:0]  wr1, wi1;

  // S2: rounded complex product
  logic                     v2, scl2;
  logic [1:0]               ctrl2;
  logic [FFT_N-2:0]         addr2;
  logic signed [FFT_DW-1:0] ar2, ai2;
  logic signed [RW-1:0]     pr2, pi2;

  // S3: unscaled butterfly results
  logic                     v3, scl3;
  logic [1:0]               ctrl3;
  logic [FFT_N-2:0]         addr3;
  logic signed [RW-1:0]     xar3, xai3, xbr3, xbi3;

  // Conjugated twiddle; the most negative value cannot be negated exactly.
  logic signed [TW_DW-1:0] wi_eff;
  assign wi_eff = !inv1 ? wi1 : (wi1 == TW_MIN) ? TW_MAX : -wi1;

  logic signed [PW-1:0] bre, bie, wre, wie, pr_full, pi_full, pr_rnd, pi_rnd;
  assign bre     = PW'(br1);
  assign bie     = PW'(bi1);
  assign wre     = PW'(wr1);
  assign wie     = PW'(wi_eff);
  assign pr_full = bre * wre - bie * wie;
  assign pi_full = bre * wie + bie * wre;
  assign pr_rnd  = pr_full + RND;
  assign pi_rnd  = pi_full + RND;

  logic unused_bits;
  assign unused_bits = ^{pr_rnd[TW_DW-2:0], pi_rnd[TW_DW-2:0]};

  function automatic logic [FFT_DW:0] scale_sat(input logic signed [RW-1:0] x,
                                                input logic scl);
    logic signed [RW:0] t;
    logic               ov;
    t  = (RW+1)'(x);
    if (scl) begin
      t = t + (RW+1)'(1);
      t = t >>> 1;
    end
    ov = 1'b0;
    if (t > S_MAX) begin
      t  = S_MAX;
      ov = 1'b1;
    end else if (t < S_MIN) begin
      t  = S_MIN;
      ov = 1'b1;
    end
    return {ov, t[FFT_DW-1:0]};
  endfunction

  logic [FFT_DW:0] sar, sai, sbr, sbi;
  assign sar = scale_sat(xar3, scl3);
  assign sai = scale_sat(xai3, scl3);
  assign sbr = scale_sat(xbr3, scl3);
  assign sbi = scale_sat(xbi3, scl3);

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0; inv1 <= 1'b0; scl1 <= 1'b0; ctrl1 <= '0; addr1 <= '0;
      ar1 <= '0; ai1 <= '0; br1 <= '0; bi1 <= '0; wr1 <= '0; wi1 <= '0;
      v2 <= 1'b0; scl2 <= 1'b0; ctrl2 <= '0; addr2 <= '0;
      ar2 <= '0; ai2 <= '0; pr2 <= '0; pi2 <= '0;
      v3 <= 1'b0; scl3 <= 1'b0; ctrl3 <= '0; addr3 <= '0;
      xar3 <= '0; xai3 <= '0; xbr3 <= '0; xbi3 <= '0;
      out_valid <= 1'b0; out_ctrl <= '0; out_addr <= '0;
      out_a <= '0; out_b <= '0; out_ovf <= 1'b0;
    end else if (ce) begin
      // Illegal-stage beats are swallowed here as bubbles.
      v1    <= in_valid & stage_ok;
      inv1  <= inverse;
      scl1  <= scale_shift;
      ctrl1 <= in_ctrl;
      addr1 <= in_addr;
      ar1   <= in_a[FFT_DW-1:0];
      ai1   <= in_a[2*FFT_DW-1:FFT_DW];
      br1   <= in_b[FFT_DW-1:0];
      bi1   <= in_b[2*FFT_DW-1:FFT_DW];
      wr1   <= tw_re;
      wi1   <= tw_im;

      v2    <= v1;
      scl2  <= scl1;
      ctrl2 <= ctrl1;
      addr2 <= addr1;
      ar2   <= ar1;
      ai2   <= ai1;
      pr2   <= pr_rnd[PW-1:TW_DW-1];
      pi2   <= pi_rnd[PW-1:TW_DW-1];

      v3    <= v2;
      scl3  <= scl2;
      ctrl3 <= ctrl2;
      addr3 <= addr2;
      xar3  <= RW'(ar2) + pr2;
      xai3  <= RW'(ai2) + pi2;
      xbr3  <= RW'(ar2) - pr2;
      xbi3  <= RW'(ai2) - pi2;

      out_valid <= v3;
      out_ctrl  <= ctrl3;
      out_addr  <= addr3;
      out_a     <= {sai[FFT_DW-1:0], sar[FFT_DW-1:0]};
      out_b     <= {sbi[FFT_DW-1:0], sbr[FFT_DW-1:0]};
      out_ovf   <= sar[FFT_DW] | sai[FFT_DW] | sbr[FFT_DW] | sbi[FFT_DW];
    end
  end

  // Sticky flags; an overflow transfer beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      stage_err  <= 1'b0;
    end else begin
      if (out_valid & out_ready & out_ovf) ovf_sticky <= 1'b1;
      else if (ovf_clear)                  ovf_sticky <= 1'b0;
      if (in_valid & ce & ~stage_ok)       stage_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_butterfly_core_scaled.sv
// Scoreboard bench for butterfly_core_scaled: directed cases plus randomized
// beats under random backpressure, checked against an arithmetic model.
`timescale 1ns/1ps
module tb_butterfly_core_scaled;
  localparam int FFT_N = 10;
  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int SBW   = 4;
  localparam int AW    = FFT_N - 1;
  localparam int EW    = 2 + AW + 4*DW + 1;

  logic            clk, reset;
  logic [SBW-1:0]  fft_stage;
  logic            inverse, scale_shift, in_valid, in_ready;
  logic [1:0]      in_ctrl, out_ctrl;
  logic [AW-1:0]   in_addr, out_addr;
  logic [2*DW-1:0] in_a, in_b, out_a, out_b;
  logic [TW-1:0]   tw_re, tw_im;
  logic            out_valid, out_ready, out_ovf, ovf_sticky, ovf_clear, stage_err;

  butterfly_core_scaled #(.FFT_N(FFT_N), .FFT_DW(DW), .TW_DW(TW), .STAGE_BW(SBW)) dut (
    .clk(clk), .reset(reset), .fft_stage(fft_stage), .inverse(inverse),
    .scale_shift(scale_shift), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_addr(in_addr), .in_a(in_a), .in_b(in_b),
    .tw_re(tw_re), .tw_im(tw_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_addr(out_addr), .out_a(out_a), .out_b(out_b),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear),
    .stage_err(stage_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int bp_mode  = 0;
  bit stall_arm = 0;
  int stall_cnt = 0;
  int n_stall   = 0;
  bit clr_req = 0;
  bit clear_on_ovf = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [DW-1:0] v);
    return longint'(signed'(v));
  endfunction

  function automatic logic [EW-1:0] model(input logic [1:0] c, input logic [AW-1:0] ad,
      input logic [2*DW-1:0] a, input logic [2*DW-1:0] b,
      input logic [TW-1:0] twr, input logic [TW-1:0] twi, input logic inv, input logic scl);
    longint ar, ai, br, bi, wr, wi, pr, pi, lim;
    longint xs[4];
    logic [DW-1:0] o[4];
    logic ov;
    ar = sx(a[DW-1:0]); ai = sx(a[2*DW-1:DW]);
    br = sx(b[DW-1:0]); bi = sx(b[2*DW-1:DW]);
    wr = sx(twr);       wi = sx(twi);
    lim = longint'(1) << (DW - 1);
    if (inv) wi = (wi == -(longint'(1) << (TW - 1))) ? (longint'(1) << (TW - 1)) - 1 : -wi;
    pr = (br * wr - bi * wi + (longint'(1) << (TW - 2))) >>> (TW - 1);
    pi = (br * wi + bi * wr + (longint'(1) << (TW - 2))) >>> (TW - 1);
    xs[0] = ar + pr; xs[1] = ai + pi; xs[2] = ar - pr; xs[3] = ai - pi;
    ov = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (scl) xs[k] = (xs[k] + 1) >>> 1;
      if (xs[k] > lim - 1) begin xs[k] = lim - 1; ov = 1'b1; end
      if (xs[k] < -lim)    begin xs[k] = -lim;    ov = 1'b1; end
      o[k] = xs[k][DW-1:0];
    end
    return {c, ad, o[1], o[0], o[3], o[2], ov};
  endfunction

  function automatic logic [EW-1:0] pk(input logic [1:0] c, input logic [AW-1:0] ad,
      input int ar, input int ai, input int br, input int bi, input logic ov);
    return {c, ad, DW'(ai), DW'(ar), DW'(bi), DW'(br), ov};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [SBW-1:0] stg, input logic inv, input logic scl,
      input logic [1:0] c, input logic [AW-1:0] ad, input logic [2*DW-1:0] a,
      input logic [2*DW-1:0] b, input logic [TW-1:0] wr, input logic [TW-1:0] wi,
      input logic use_exp, input logic [EW-1:0] exp_v);
    int guard;
    @(negedge clk);
    fft_stage = stg; inverse = inv; scale_shift = scl; in_ctrl = c; in_addr = ad;
    in_a = a; in_b = b; tw_re = wr; tw_im = wi; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    else if (32'(stg) < FFT_N)
      exp_q.push_back(use_exp ? exp_v : model(c, ad, a, b, wr, wi, inv, scl));
  endtask

  task automatic send_rand(input logic [SBW-1:0] stg, input logic [AW-1:0] ad);
    logic [TW-1:0] wi;
    wi = ($urandom_range(0, 9) == 0) ? 16'h8000 : TW'($urandom);
    send(stg, 1'($urandom), 1'($urandom), 2'($urandom), ad, $urandom, $urandom,
         TW'($urandom), wi, 1'b0, '0);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    idle();
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("drain", 128'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- backpressure ----------------
  always @(posedge clk) begin
    #1;
    if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else if (bp_mode == 2 && stall_arm && out_valid) begin
      out_ready = 1'b0; stall_cnt = 2; stall_arm = 0;
    end else if (stall_cnt > 0) begin
      out_ready = 1'b0; stall_cnt--;
    end else out_ready = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [EW-1:0] held;
  bit            held_v = 0;
  bit            chk_set_wins = 0;
  initial begin
    logic [EW-1:0] act, e;
    ovf_clear = 1'b0;
    forever begin
      @(negedge clk);
      if (ovf_clear) begin
        ovf_clear = 1'b0;
        if (chk_set_wins) check("ovf_set_wins", ovf_sticky, 1);
        chk_set_wins = 0;
      end
      if (clr_req) begin
        ovf_clear = 1'b1;
        clr_req = 0;
      end
      if (reset) begin
        held_v = 0;
      end else begin
        act = {out_ctrl, out_addr, out_a, out_b, out_ovf};
        if (held_v && out_valid) check("hold_stable", act, held);
        held_v = 0;
        if (out_valid && !out_ready) begin
          check("in_ready_stall", in_ready, 0);
          held = act; held_v = 1; n_stall++;
        end else if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("unexpected_beat", act, 0);
          else begin
            e = exp_q.pop_front();
            check("beat", act, e);
            if (clear_on_ovf && out_ovf) begin
              ovf_clear = 1'b1; chk_set_wins = 1;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; fft_stage = '0; inverse = 0; scale_shift = 0;
    in_ctrl = '0; in_addr = '0; in_a = '0; in_b = '0; tw_re = '0; tw_im = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_sticky", ovf_sticky, 0);
    check("rst_stage_err", stage_err, 0);
    check("rst_out_a", out_a, 0);

    // Unity-ish twiddle, with and without scaling
    send(0, 0, 0, 2'd1, 9'd1, {16'd0, 16'd1000}, {16'd0, 16'd2000}, 16'd16384, 16'd0,
         1, pk(2'd1, 9'd1, 2000, 0, 0, 0, 0));
    send(0, 0, 1, 2'd1, 9'd2, {16'd0, 16'd1000}, {16'd0, 16'd2000}, 16'd16384, 16'd0,
         1, pk(2'd1, 9'd2, 1000, 0, 0, 0, 0));
    // -j twiddle; conjugated variant saturates the negation
    send(1, 0, 0, 2'd2, 9'd3, 32'd0, {16'd50, 16'd100}, 16'd0, 16'h8000,
         1, pk(2'd2, 9'd3, 50, -100, -50, 100, 0));
    send(1, 1, 0, 2'd2, 9'd4, 32'd0, {16'd50, 16'd100}, 16'd0, 16'h8000,
         1, pk(2'd2, 9'd4, -50, 100, 50, -100, 0));
    drain();
    check("sticky_no_ovf", ovf_sticky, 0);

    // Saturation
    send(2, 0, 0, 2'd3, 9'd5, {16'd0, 16'd32767}, {16'd0, 16'd32767}, 16'd32767, 16'd0,
         1, pk(2'd3, 9'd5, 32767, 0, 1, 0, 1));
    drain();
    check("sticky_set", ovf_sticky, 1);
    clr_req = 1;
    repeat (3) @(negedge clk);
    check("sticky_cleared", ovf_sticky, 0);
    send(2, 0, 1, 2'd3, 9'd6, {16'd0, 16'd32767}, {16'd0, 16'd32767}, 16'd32767, 16'd0,
         1, pk(2'd3, 9'd6, 32767, 0, 1, 0, 0));
    drain();
    check("sticky_scaled_no_ovf", ovf_sticky, 0);

    // Back-to-back stream with a 3-cycle stall on the first output
    bp_mode = 2; stall_arm = 1; n_stall = 0;
    for (int i = 0; i < 8; i++) send_rand(4'(i % FFT_N), AW'(i));
    drain();
    check("stall_seen", 128'(n_stall >= 3), 1);
    bp_mode = 0;

    // Illegal stage between legal beats
    send_rand(4'd3, 9'd20);
    send_rand(4'd10, 9'd21);
    send_rand(4'd9, 9'd22);
    drain();
    check("stage_err_set", stage_err, 1);

    // Clear coinciding with an overflow transfer
    clear_on_ovf = 1;
    send(0, 0, 0, 2'd0, 9'd30, {16'd0, 16'h8000}, {16'd0, 16'h8000}, 16'd32767, 16'd0,
         1, pk(2'd0, 9'd30, -32768, 0, -1, 0, 1));
    drain();
    clear_on_ovf = 0;
    check("sticky_after_set_wins", ovf_sticky, 1);

    // Random beats under random backpressure
    bp_mode = 1;
    for (int i = 0; i < 300; i++)
      send_rand(($urandom_range(0, 7) == 0) ? 4'(10 + $urandom_range(0, 5))
                                           : 4'($urandom_range(0, 9)), AW'($urandom));
    drain();
    bp_mode = 0;

    // Reset with three beats in flight
    send(0, 0, 0, 2'd1, 9'd40, {16'd0, 16'd32767}, {16'd0, 16'd32767}, 16'd32767, 16'd0,
         1, pk(2'd1, 9'd40, 32767, 0, 1, 0, 1));
    drain();
    for (int i = 0; i < 3; i++) send_rand(4'd0, AW'(50 + i));
    @(negedge clk);
    in_valid = 1'b0;
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_sticky", ovf_sticky, 0);
    check("mid_rst_stage_err", stage_err, 0);
    check("mid_rst_out_ovf", out_ovf, 0);
    check("mid_rst_out_addr", out_addr, 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    repeat (12) @(negedge clk);
    send_rand(4'd5, 9'd60);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/butterfly_core_scaled.md
Name: butterfly_core_scaled

Overview:
- Next-generation radix-2 DIT butterfly core for the in-place FFT engine. It sits between the dual-port sample RAM read path and the write-back path.
- One shared, fully pipelined datapath serves every stage. Adds four things: valid/ready backpressure, runtime inverse (IFFT) mode, per-beat divide-by-2 scaling with rounding, and output saturation with overflow reporting.
- Sideband fields (address, ctrl) travel with their data through the pipeline.

Parameters:
- FFT_N, 10, log2 of FFT length; legal stages 0..FFT_N-1.
- FFT_DW, 16, bits per real/imag component of data.
- TW_DW, 16, bits per twiddle component; signed Q1.(TW_DW-1).
- STAGE_BW, 4, width of fft_stage.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- fft_stage  in  STAGE_BW  stage tag of the input beat.
- inverse  in  1  1 = use conjugated twiddle.
- scale_shift  in  1  1 = divide both outputs by 2 with rounding.
- in_valid  in  1  input beat present.
- in_ready  out  1  core accepts a beat this cycle.
- in_ctrl  in  2  sideband, passed through unchanged.
- in_addr  in  FFT_N-1  pair address, passed through unchanged.
- in_a  in  2*FFT_DW  {imag,real}, signed.
- in_b  in  2*FFT_DW  {imag,real}, signed.
- tw_re  in  TW_DW  twiddle real, signed; valid with the beat.
- tw_im  in  TW_DW  twiddle imag, signed; valid with the beat.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts the output beat.
- out_ctrl  out  2  sideband of the output beat.
- out_addr  out  FFT_N-1  address of the output beat.
- out_a  out  2*FFT_DW  A + B·W.
- out_b  out  2*FFT_DW  A − B·W.
- out_ovf  out  1  a saturation occurred in this output beat.
- ovf_sticky  out  1  latched OR of out_ovf on transferred beats.
- ovf_clear  in  1  clears ovf_sticky.
- stage_err  out  1  sticky; a beat with fft_stage ≥ FFT_N was accepted.

Behaviour:
- Transfer rules: input transfer = in_valid & in_ready. Output transfer = out_valid & out_ready.
- Pipeline: 4 register stages; latency 4 cycles from input transfer to out_valid with no stall.
  - S1 captures data, twiddle, sideband, inverse, scale_shift.
  - S2 computes the complex product.
  - S3 computes sum/difference.
  - S4 scales, saturates and drives the outputs.
- Stall: ce = ~out_valid | out_ready. All stages advance only when ce is high; in_ready = ce (combinational). Bubbles propagate as valid=0, and valid bits shift only on ce. Throughput is 1 beat/cycle. No beat is lost or reordered, and outputs hold stable while stalled.
- Per-beat mode: inverse, scale_shift and fft_stage are sampled at the input transfer. Changing them between beats affects only later beats.
- Illegal stage: a beat with fft_stage ≥ FFT_N is accepted (in_ready unaffected) but its valid is cleared at S1. It produces no output and sets stage_err. stage_err clears only on reset.
- Conjugation: when inverse=1, wi = −tw_im. −(−2^(TW_DW−1)) saturates to 2^(TW_DW−1)−1.
- Product:
  - pr = br·wr − bi·wi; pi = br·wi + bi·wr, each at full precision (FFT_DW+TW_DW+1 bits).
  - Rounding: add 2^(TW_DW−2), then arithmetic shift right by TW_DW−1 (round half up). Result p is FFT_DW+2 bits.
- Butterfly: a' = a + p, b' = a − p, computed per component at FFT_DW+2 bits, no wrap.
- Scale: if scale_shift, x = (x + 1) >>> 1; otherwise unchanged.
- Saturate: clamp each of the 4 components to [−2^(FFT_DW−1), 2^(FFT_DW−1)−1]. out_ovf = OR of the 4 clamp events.
- Overflow reporting:
  - ovf_sticky is set on an output transfer with out_ovf=1.
  - ovf_clear clears it. If set and clear occur in the same cycle, set wins.
- Reset:
  - All valid bits, out_valid, out_ovf, ovf_sticky and stage_err go to 0.
  - out_a, out_b, out_addr and out_ctrl go to 0.
  - in_ready is 1 in the cycle after reset deasserts.
  - Reset mid-stream discards all in-flight beats; no output follows.

Test Plan:
- DW=TW=16, A=(1000,0), B=(2000,0), W=(16384,0), scale=0, out_ready=1 -> 4 cycles later out_a=(2000,0), out_b=(0,0), out_ovf=0. Same beat with scale=1 -> out_a=(1000,0), out_b=(0,0).
- A=(0,0), B=(100,50) as (re,im), W=(0,−32768), inverse=0 -> out_a=(50,−100), out_b=(−50,100). Same beat with inverse=1 (wi=+32767) -> out_a=(−50,100), out_b=(50,−100).
- A=(32767,0), B=(32767,0), W=(32767,0), scale=0 -> out_a=(32767,0) with out_ovf=1, out_b=(1,0), ovf_sticky=1. Same beat with scale=1 -> out_a=(32767,0), out_ovf=0, out_b=(1,0).
- Stream 8 beats (addr 0..7) back-to-back; hold out_ready=0 for 3 cycles after the first output -> in_ready=0 during the stall, outputs stable, all 8 addresses emerge in order exactly once.
- Beat with fft_stage=10 between legal beats -> no output for it, stage_err=1, neighbouring beats unaffected. ovf_clear asserted in the same cycle as an overflow transfer -> ovf_sticky remains 1.
- Assert reset with 3 beats in flight -> out_valid=0 and all flags 0 the next cycle; no stale beat appears afterwards.
